fetch_queue_stage: RTL

- Parametrised fetch stage for the pipelined processor.
- Owns the PC and issues one sequential fetch per cycle to a synchronous instruction memory (1-cycle read latency).
- Buffers returned instructions, with their PC and PC+increment, in a QDEPTH-entry FIFO feeding decode through a valid/stall handshake.
- A redirect from execute flushes queued and in-flight fetches and restarts at the target.

---
 rtl/fetch_queue_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/fetch_queue_stage.sv
// Fetch stage: owns the PC, issues sequential fetches to a 1-cycle synchronous
// instruction memory and queues the returned instructions for decode.
module fetch_queue_stage #(
    parameter int IW     = 33,
    parameter int AW     = 9,
    parameter int PC_INC = 1,
    parameter int QDEPTH = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_e,
    input  logic [AW-1:0]               redirect_pc_e,
    input  logic                        stall_d,
    output logic [AW-1:0]               imem_addr,
    output logic                        imem_en,
    input  logic [IW-1:0]               imem_rdata,
    output logic                        valid_d,
    output logic [IW-1:0]               instr_d,
    output logic [AW-1:0]               pc_d,
    output logic [AW-1:0]               pc_plus_d,
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fetch_pc;
    logic [AW-1:0] resp_pc;
    logic          inflight;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [IW-1:0] instr_mem   [QDEPTH];
    logic [AW-1:0] pc_mem      [QDEPTH];
    logic [AW-1:0] pc_plus_mem [QDEPTH];

    logic issue;
    logic push;
    logic pop;

    // Credit rule: queued entries plus the outstanding fetch never exceed QDEPTH,
    // so every returning response has a free slot.
    assign issue = !rst && !redirect_e && ((count + CW'(inflight)) < CW'(QDEPTH));
    assign push  = inflight && !redirect_e;
    assign pop   = valid_d && !stall_d && !redirect_e;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect_e) begin
            // Flush wins over stall and pop; the in-flight response is dropped.
            fetch_pc <= redirect_pc_e;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + AW'(PC_INC);
                resp_pc  <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: queue storage has no reset; stale slots are never observed because
    // the outputs are gated by count, and leaving it unreset keeps it plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr]   <= imem_rdata;
            pc_mem[wr_ptr]      <= resp_pc;
            pc_plus_mem[wr_ptr] <= resp_pc + AW'(PC_INC);
        end
    end

    assign imem_addr = fetch_pc;
    assign imem_en   = issue;
    assign q_count   = count;
    assign valid_d   = (count != '0);
    assign instr_d   = valid_d ? instr_mem[rd_ptr]   : '0;
    assign pc_d      = valid_d ? pc_mem[rd_ptr]      : '0;
    assign pc_plus_d = valid_d ? pc_plus_mem[rd_ptr] : '0;

endmodule
